display_scan: RTL and testbench
===============================

# display_scan

Display-side receiver for the calculator's `pos`/`data`/`status` output interface. It captures digit writes into an 8-entry digit buffer and drives an 8-digit, active-low, common-anode seven-segment display by time-multiplexing. It also substitutes an "Error" pattern whenever the calculator reports an error. It sits between the calculator core and the board display pins.

## Interface
- `SCAN_DIV`, default 100000: clock cycles each digit stays enabled; legal values are ≥ 2.
- `clock`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-low reset.
- `status`  in  2  calculator state: 00 ERRO, 01 PRONTA, 10 OCUPADA, 11 treated as ERRO.
- `pos`  in  4  digit position to write; 0 is the rightmost digit.
- `data`  in  4  digit value: 0–9 numeric, 10–14 dash, 15 blank.
- `an`  out  8  digit enables, active-low; bit i drives digit i.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-low.
- `dp`  out  1  decimal point, active-low.

## Operation
- **Buffer write**
  - Every cycle with `status`==PRONTA and `pos`<8: `buf[pos]` <= `data`.
  - `pos`≥8 is ignored.
  - No write occurs in OCUPADA, ERRO or 11; the buffer is frozen.
- **Scan**
  - Prescaler `pre` counts 0..SCAN_DIV-1.
  - When `pre`==SCAN_DIV-1, `pre` wraps to 0 and digit index `idx` increments mod 8 (7→0).
- **Display mode**
  - In ERRO (or 11), the buffer is ignored and the display shows: digits 7..5 blank, 4 'E', 3 'r', 2 'r', 1 'o', 0 'r'.
  - In PRONTA or OCUPADA, the display shows the decoded `buf[idx]`.
- **Decode**
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - dash=0111111, blank=1111111, E=0000110, r=0101111, o=0100011.
- **Busy indicator:** `dp` is 0 only when `status`==OCUPADA and `idx`==0; otherwise 1.
- **ERRO exit:** leaving ERRO restores buffer display; the buffer contents were kept unchanged throughout.

## Timing
- **Reset** (`reset`==0 at a rising edge):
  - `an`=8'hFF, `seg`=7'h7F, `dp`=1.
  - `pre`=0, `idx`=0, all `buf` entries = 0.
- Reset asserted mid-scan aborts the scan on that edge; the first enabled digit after release is digit 0.
- `an`, `seg` and `dp` are registered from the current `idx`, `buf` and `status`, so they lag them by one cycle. `an` = ~(1<<idx).
- **Write-to-display latency:** a write at edge N updates `buf` at N. `seg` reflects the new value at edge N+1 if that digit is being scanned.
- **Write and scan on the same edge:** the output register samples the pre-write value.
- **Scan period:** each digit is enabled for exactly SCAN_DIV cycles; a full refresh takes 8·SCAN_DIV cycles.
- **Status changes:** ERRO takes effect on `seg` one cycle after `status` changes, independent of scan phase.

## Configuration
- `LEADING_ZERO_BLANK_EN` defined: digit i (7..1) displays blank when `buf[i]`==0 and every `buf[j]` for j>i is 0 or 15. Digit 0 is never blanked. This applies in PRONTA and OCUPADA only.
- Macro undefined: all stored zeros are displayed.

## Structure
- **Shared package `calc_pkg`:**
  - `estado_t` enum (ERRO/PRONTA/OCUPADA), shared with the calculator core.
  - Data codes (DASH 10–14, BLANK 15).
  - Active-low segment constants for digits, dash, blank, E, r, o.
- **Sub-module `seg7_decoder`:** purely combinational, 4-bit code → 7-bit active-low pattern. Instantiated once, ahead of the output register; the Error glyphs are muxed in after it.

## Test plan
- **Reset:** hold `reset`=0 for 3 cycles → `an`=FF, `seg`=7F, `dp`=1. First edge after release: `an`=FE, `seg`=1000000 (macro off).
- **Write and scan:** SCAN_DIV=4, PRONTA, write `pos`=3 `data`=7 → while `an`=F7 (cycles 12–15 of the scan), `seg`=1111000. Each digit is enabled for exactly 4 cycles.
- **Error pattern:** drive `status`=00 → digits 4..0 show E,r,r,o,r and 7..5 blank. Writes are ignored. On return to 01, the prior buffer reappears.
- **Busy and frozen buffer:** `status`=10 with `pos`=0 `data`=5 → buffer unchanged, `dp`=0 only while `an`=FE.
- **Leading-zero blanking:** macro on, buffer digits 7..0 = 0,0,0,0,1,0,0,2 → digits 7..4 blank, digits 2 and 1 show 0. All-zero buffer shows a single '0'.
- **Boundary inputs:** `pos`=9 with `data`=3 → no buffer change. `data`=15 at `pos`=0 → digit 0 blank. Reset asserted at `idx`=5 → `idx` restarts at 0.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared calculator package: status encoding, data codes and segment glyphs.
// Used by the calculator core and by the display_scan receiver.
package calc_pkg;

  typedef enum logic [1:0] {
    ERRO    = 2'b00,
    PRONTA  = 2'b01,
    OCUPADA = 2'b10
  } estado_t;

  localparam logic [3:0] DASH_MIN = 4'd10;
  localparam logic [3:0] DASH_MAX = 4'd14;
  localparam logic [3:0] BLANK    = 4'd15;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_R     = 7'b0101111;
  localparam logic [6:0] SEG_O     = 7'b0100011;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational 4-bit digit code to active-low seven-segment pattern.
// Codes 10..14 render a dash, 15 renders blank.
module seg7_decoder
  import calc_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    unique case (code)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      BLANK:   seg = SEG_BLANK;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/display_scan.sv
// 8-digit multiplexed display receiver with error pattern substitution.
// Optional LEADING_ZERO_BLANK_EN blanks leading zeros on digits 7..1.
module display_scan
  import calc_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] status,
  input  logic [3:0] pos,
  input  logic [3:0] data,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);

  logic [PW-1:0] pre;
  logic [2:0]    idx;
  logic [3:0]    digits [8];
  logic [3:0]    cur;
  logic [6:0]    dec_seg;
  logic [6:0]    err_seg;
  logic [6:0]    seg_nxt;
  logic          is_err;
  logic          wr_en;
  logic          lz_blank;

  assign cur    = digits[idx];
  assign is_err = !(status == PRONTA || status == OCUPADA);
  assign wr_en  = (status == PRONTA) && !pos[3];

  seg7_decoder u_dec (
    .code (cur),
    .seg  (dec_seg)
  );

  always_comb begin
    err_seg = SEG_BLANK;
    unique case (idx)
      3'd4:    err_seg = SEG_E;
      3'd3:    err_seg = SEG_R;
      3'd2:    err_seg = SEG_R;
      3'd1:    err_seg = SEG_O;
      3'd0:    err_seg = SEG_R;
      default: err_seg = SEG_BLANK;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Blank a zero only if every more-significant digit is zero or blank
  always_comb begin
    lz_blank = (idx != 3'd0) && (cur == 4'd0);
    for (int j = 0; j < 8; j++) begin
      if (j > int'(idx) && digits[j] != 4'd0 && digits[j] != BLANK)
        lz_blank = 1'b0;
    end
  end
`else
  assign lz_blank = 1'b0;
`endif

  assign seg_nxt = is_err   ? err_seg   :
                   lz_blank ? SEG_BLANK : dec_seg;

  always_ff @(posedge clock) begin
    if (!reset) begin
      pre <= '0;
      idx <= '0;
      for (int i = 0; i < 8; i++) digits[i] <= '0;
      an  <= 8'hFF;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      if (pre == PRE_MAX) begin
        pre <= '0;
        idx <= idx + 3'd1;
      end else begin
        pre <= pre + 1'b1;
      end
      if (wr_en) digits[pos[2:0]] <= data;
      an  <= ~(8'd1 << idx);
      seg <= seg_nxt;
      dp  <= ~((status == OCUPADA) && (idx == 3'd0));
    end
  end

endmodule

// File: tb/tb_display_scan.sv
// Randomized bench for display_scan against a cycle-count reference model.
// Define LEADING_ZERO_BLANK_EN to exercise the blanking variant.
module tb_display_scan;

  localparam int SD = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] status = 2'b01;
  logic [3:0] pos = 4'd8;
  logic [3:0] data = 4'd0;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;

  int checks = 0;
  int errors = 0;

  display_scan #(.SCAN_DIV(SD)) dut (
    .clock  (clock),
    .reset  (reset),
    .status (status),
    .pos    (pos),
    .data   (data),
    .an     (an),
    .seg    (seg),
    .dp     (dp)
  );

  always #5 clock = ~clock;

  logic [6:0] glyph [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
    7'b0111111, 7'b0111111, 7'b0111111, 7'b1111111
  };
  logic [6:0] errp [8] = '{
    7'b0101111, 7'b0100011, 7'b0101111, 7'b0101111,
    7'b0000110, 7'b1111111, 7'b1111111, 7'b1111111
  };

  logic [3:0] mbuf [8];
  int         cnt = 0;
  logic [7:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp;

  function automatic logic lzb(int i);
`ifdef LEADING_ZERO_BLANK_EN
    if (i == 0 || mbuf[i] != 4'd0) return 1'b0;
    for (int j = i + 1; j < 8; j++)
      if (mbuf[j] != 4'd0 && mbuf[j] != 4'd15) return 1'b0;
    return 1'b1;
`else
    return (i < 0);
`endif
  endfunction

  function automatic logic [6:0] model_seg(int i);
    if (!(status == 2'b01 || status == 2'b10)) return errp[i];
    if (lzb(i)) return 7'b1111111;
    return glyph[mbuf[i]];
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    int ix;
    @(posedge clock);
    if (!reset) begin
      e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; cnt = 0;
      for (int i = 0; i < 8; i++) mbuf[i] = 4'd0;
    end else begin
      ix    = (cnt / SD) % 8;
      e_an  = ~(8'd1 << ix);
      e_seg = model_seg(ix);
      e_dp  = !(status == 2'b10 && ix == 0);
      if (status == 2'b01 && pos < 4'd8) mbuf[pos[2:0]] = data;
      cnt++;
    end
    @(negedge clock);
    chk("an", an, e_an);
    chk("seg", seg, e_seg);
    chk("dp", dp, e_dp);
  endtask

  task automatic wr(logic [3:0] p, logic [3:0] d);
    status = 2'b01; pos = p; data = d;
    step();
    pos = 4'd8;
  endtask

  initial begin
    int n;
    logic found;
    for (int i = 0; i < 8; i++) mbuf[i] = 4'd0;
    reset = 1'b0;
    repeat (3) step();
    chk("rst_an", an, 8'hFF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", dp, 1'b1);
    reset = 1'b1; status = 2'b01; pos = 4'd8;
    step();
    chk("rel_an", an, 8'hFE);
`ifdef LEADING_ZERO_BLANK_EN
    chk("rel_seg", seg, 7'b1000000);
`else
    chk("rel_seg", seg, 7'b1000000);
`endif

    wr(4'd3, 4'd7);
    pos = 4'd9; data = 4'd3;
    n = 0;
    for (int k = 0; k < 32; k++) begin
      step();
      if (an == 8'hF7) begin
        n++;
        chk("dig3_seven", seg, 7'b1111000);
      end
      if (an == 8'hFD) chk("pos9_ignored", seg, glyph[0] | {7{lzb(1)}});
    end
    chk("dig3_width", n, SD);

    status = 2'b00;
    for (int k = 0; k < 40; k++) begin
      pos = 4'($urandom_range(0, 7)); data = 4'($urandom_range(0, 15));
      step();
      if (an == 8'hEF) chk("err_E", seg, 7'b0000110);
      if (an == 8'h7F) chk("err_blank7", seg, 7'b1111111);
    end
    status = 2'b11;
    repeat (12) step();
    status = 2'b01; pos = 4'd8;
    for (int k = 0; k < 34; k++) begin
      step();
      if (an == 8'hF7) chk("restore_dig3", seg, 7'b1111000);
    end

    status = 2'b10; pos = 4'd0; data = 4'd5;
    for (int k = 0; k < 34; k++) begin
      step();
      if (an == 8'hFE) chk("busy_dp0", dp, 1'b0);
      else             chk("busy_dp1", dp, 1'b1);
    end

    wr(4'd0, 4'd15);
    for (int k = 0; k < 34; k++) begin
      step();
      if (an == 8'hFE) chk("blank15", seg, 7'b1111111);
    end

    wr(4'd7, 4'd0); wr(4'd6, 4'd0); wr(4'd5, 4'd0); wr(4'd4, 4'd0);
    wr(4'd3, 4'd1); wr(4'd2, 4'd0); wr(4'd1, 4'd0); wr(4'd0, 4'd2);
    for (int k = 0; k < 34; k++) begin
      step();
      if (an == 8'hFB) chk("lz_dig2", seg, 7'b1000000);
`ifdef LEADING_ZERO_BLANK_EN
      if (an == 8'hEF) chk("lz_dig4", seg, 7'b1111111);
`else
      if (an == 8'hEF) chk("lz_dig4", seg, 7'b1000000);
`endif
    end
    wr(4'd3, 4'd0); wr(4'd0, 4'd0);
    for (int k = 0; k < 34; k++) begin
      step();
      if (an == 8'hFE) chk("zero_dig0", seg, 7'b1000000);
    end

    for (int k = 0; k < 400; k++) begin
      status = 2'($urandom_range(0, 3));
      pos    = 4'($urandom_range(0, 15));
      data   = 4'($urandom);
      if ($urandom_range(0, 3) != 0) status = 2'b01;
      step();
    end

    status = 2'b01; pos = 4'd8;
    found = 1'b0;
    for (int k = 0; k < 64 && !found; k++) begin
      if ((cnt / SD) % 8 == 5 && (cnt % SD) == 1) found = 1'b1;
      else step();
    end
    chk("find_idx5", found, 1'b1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    chk("rst_mid_an", an, 8'hFE);
    repeat (40) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
